// File: rtl/tcam_update_ctrl.sv
// rtl/tcam_update_ctrl.sv - TCAM rule update sequencer with valid bitmap and post-reset scrub
// Optional feature macro: TCAM_UPD_CNT_EN (saturating completed-command counter on op_count)
module tcam_update_ctrl #(
    parameter int KEY_W   = 128,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [IDX_W-1:0]   cmd_addr,
    input  logic [KEY_W-1:0]   cmd_value,
    input  logic [KEY_W-1:0]   cmd_mask,
    output logic               tcam_wr_en,
    output logic               tcam_wr_is_mask,
    output logic [IDX_W-1:0]   tcam_wr_addr,
    output logic [KEY_W-1:0]   tcam_wr_data,
    output logic [ENTRIES-1:0] entry_valid,
    output logic               cmd_done,
    output logic               init_done,
    output logic [15:0]        op_count
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR_VAL  = 3'd2,
        S_WR_MASK = 3'd3,
        S_SCRUB   = 3'd4
    } state_t;

    localparam logic [1:0]   OP_WRITE = 2'b00;
    localparam logic [1:0]   OP_INVAL = 2'b01;
    localparam logic [1:0]   OP_CLEAR = 2'b10;
    localparam logic [IDX_W:0] SWEEP_END = (IDX_W+1)'(ENTRIES);

    state_t             state_q, state_d;
    // Sweep pointer names the next (entry, phase) write to issue; one extra bit so ENTRIES is reachable.
    logic [IDX_W:0]     idx_q, idx_d;
    logic               phase_q, phase_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [KEY_W-1:0]   mask_q, mask_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic               done_q, done_d;
    logic               init_q, init_d;
    logic               wr_en_q, wr_en_d;
    logic               wr_mask_q, wr_mask_d;
    logic [IDX_W-1:0]   wr_addr_q, wr_addr_d;
    logic [KEY_W-1:0]   wr_data_q, wr_data_d;

    logic accept;
    logic sweep_end;

    assign cmd_ready       = (state_q == S_IDLE);
    assign accept          = cmd_valid && cmd_ready;
    assign sweep_end       = (idx_q == SWEEP_END);

    assign tcam_wr_en      = wr_en_q;
    assign tcam_wr_is_mask = wr_mask_q;
    assign tcam_wr_addr    = wr_addr_q;
    assign tcam_wr_data    = wr_data_q;
    assign entry_valid     = valid_q;
    assign cmd_done        = done_q;
    assign init_done       = init_q;

    // State register and all registered outputs; reset restarts the scrub from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_INIT;
            idx_q     <= '0;
            phase_q   <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            init_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_mask_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            init_q    <= init_d;
            wr_en_q   <= wr_en_d;
            wr_mask_q <= wr_mask_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (sweep_end) state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: state_d = S_WR_VAL;
                        OP_CLEAR: state_d = S_SCRUB;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_VAL:  state_d = S_WR_MASK;
            S_WR_MASK: state_d = S_IDLE;
            S_SCRUB:   if (sweep_end) state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // Output and datapath logic; write-port values are computed one cycle ahead so they leave flops.
    always_comb begin
        idx_d     = idx_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        init_d    = init_q;
        wr_en_d   = 1'b0;
        wr_mask_d = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_q)
            S_INIT, S_SCRUB: begin
                if (!sweep_end) begin
                    wr_en_d   = 1'b1;
                    wr_mask_d = phase_q;
                    wr_addr_d = idx_q[IDX_W-1:0];
                    if (phase_q) begin
                        idx_d   = idx_q + 1'b1;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else if (state_q == S_INIT) begin
                    init_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    addr_d = cmd_addr;
                    mask_d = cmd_mask;
                    case (cmd_op)
                        OP_WRITE: begin
                            // Entry reads invalid for the whole update so lookups never hit a half-written rule.
                            valid_d[cmd_addr] = 1'b0;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cmd_addr;
                            wr_data_d = cmd_value;
                        end
                        OP_INVAL: begin
                            valid_d[cmd_addr] = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            // First scrub write (entry 0 value) issues straight from the accept edge.
                            valid_d = '0;
                            wr_en_d = 1'b1;
                            idx_d   = '0;
                            phase_d = 1'b1;
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_WR_VAL: begin
                wr_en_d   = 1'b1;
                wr_mask_d = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = mask_q;
            end
            S_WR_MASK: begin
                valid_d[addr_q] = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

`ifdef TCAM_UPD_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of completed commands; only rst clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (done_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign op_count = cnt_q;
`else
    assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// tb/tb_tcam_update_ctrl.sv - scoreboard bench for tcam_update_ctrl
module tb_tcam_update_ctrl;

    localparam int KEY_W   = 128;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    typedef struct {
        logic             m;
        logic [IDX_W-1:0] a;
        logic [KEY_W-1:0] d;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [IDX_W-1:0]   cmd_addr;
    logic [KEY_W-1:0]   cmd_value;
    logic [KEY_W-1:0]   cmd_mask;
    logic               tcam_wr_en;
    logic               tcam_wr_is_mask;
    logic [IDX_W-1:0]   tcam_wr_addr;
    logic [KEY_W-1:0]   tcam_wr_data;
    logic [ENTRIES-1:0] entry_valid;
    logic               cmd_done;
    logic               init_done;
    logic [15:0]        op_count;

    wr_t                wq[$];
    logic [ENTRIES-1:0] dq[$];
    logic [ENTRIES-1:0] exp_valid;
    int                 exp_ops;
    int                 checks;
    int                 errors;
    wr_t                got;
    int                 waited;

    tcam_update_ctrl #(.KEY_W(KEY_W), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_mask(cmd_mask),
        .tcam_wr_en(tcam_wr_en), .tcam_wr_is_mask(tcam_wr_is_mask),
        .tcam_wr_addr(tcam_wr_addr), .tcam_wr_data(tcam_wr_data),
        .entry_valid(entry_valid), .cmd_done(cmd_done),
        .init_done(init_done), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef TCAM_UPD_CNT_EN
        return 16'(exp_ops);
`else
        return 16'd0;
`endif
    endfunction

    task automatic push_sweep();
        for (int i = 0; i < ENTRIES; i++) begin
            wq.push_back('{m: 1'b0, a: IDX_W'(i), d: '0});
            wq.push_back('{m: 1'b1, a: IDX_W'(i), d: '0});
        end
    endtask

    // Called at a negedge; returns #1 after the accept edge with the number of negedges waited.
    task automatic issue(input logic [1:0] op, input logic [IDX_W-1:0] a,
                         input logic [KEY_W-1:0] v, input logic [KEY_W-1:0] m, output int n);
        logic [ENTRIES-1:0] bit_a;
        bit_a = '0;
        bit_a[a] = 1'b1;
        cmd_op = op; cmd_addr = a; cmd_value = v; cmd_mask = m; cmd_valid = 1'b1;
        case (op)
            2'd0: begin
                wq.push_back('{m: 1'b0, a: a, d: v});
                wq.push_back('{m: 1'b1, a: a, d: m});
                exp_valid = exp_valid | bit_a;
            end
            2'd1: exp_valid = exp_valid & ~bit_a;
            2'd2: begin
                push_sweep();
                exp_valid = '0;
            end
            default: exp_valid = exp_valid;
        endcase
        dq.push_back(exp_valid);
        exp_ops++;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Scoreboard: every TCAM write and every cmd_done is matched against the expected queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (tcam_wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    got = wq.pop_front();
                    chk("wr_is_mask", KEY_W'(tcam_wr_is_mask), KEY_W'(got.m));
                    chk("wr_addr", KEY_W'(tcam_wr_addr), KEY_W'(got.a));
                    chk("wr_data", tcam_wr_data, got.d);
                end
            end else begin
                chk("wr_idle_zero", KEY_W'(tcam_wr_is_mask || (tcam_wr_addr != 0) || (tcam_wr_data != 0)), 0);
            end
            if (cmd_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_valid", KEY_W'(entry_valid), KEY_W'(dq.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; exp_ops = 0; exp_valid = '0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_value = '0; cmd_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", KEY_W'(tcam_wr_en), 0);
        chk("rst_wr_data", tcam_wr_data, 0);
        chk("rst_ready", KEY_W'(cmd_ready), 0);
        chk("rst_init_done", KEY_W'(init_done), 0);
        chk("rst_cmd_done", KEY_W'(cmd_done), 0);
        chk("rst_valid", KEY_W'(entry_valid), 0);
        chk("rst_op_count", KEY_W'(op_count), 0);

        // Post-reset scrub: 32 writes, then init_done with cmd_ready.
        push_sweep();
        rst = 1'b0;
        @(negedge clk);
        chk("init_first_wr", KEY_W'(tcam_wr_en), 1);
        repeat (31) @(negedge clk);
        chk("init_done_early", KEY_W'(init_done), 0);
        chk("init_ready_early", KEY_W'(cmd_ready), 0);
        @(negedge clk);
        chk("init_done", KEY_W'(init_done), 1);
        chk("init_ready", KEY_W'(cmd_ready), 1);
        chk("init_valid", KEY_W'(entry_valid), 0);
        chk("init_sweep_drained", KEY_W'(wq.size()), 0);

        // Single write to entry 5.
        issue(2'd0, 4'd5, 128'hAB, 128'h0F, waited);
        @(negedge clk);
        chk("w5_c1_wr_en", KEY_W'(tcam_wr_en), 1);
        chk("w5_c1_is_mask", KEY_W'(tcam_wr_is_mask), 0);
        chk("w5_c1_ready", KEY_W'(cmd_ready), 0);
        chk("w5_c1_valid", KEY_W'(entry_valid), 0);
        @(negedge clk);
        chk("w5_c2_is_mask", KEY_W'(tcam_wr_is_mask), 1);
        chk("w5_c2_done", KEY_W'(cmd_done), 0);
        @(negedge clk);
        chk("w5_c3_valid", KEY_W'(entry_valid), 16'h0020);
        chk("w5_c3_done", KEY_W'(cmd_done), 1);
        chk("w5_c3_ready", KEY_W'(cmd_ready), 1);

        // Invalidate entry 5, then a reserved op.
        issue(2'd1, 4'd5, '0, '0, waited);
        @(negedge clk);
        chk("inv_valid", KEY_W'(entry_valid), 0);
        chk("inv_done", KEY_W'(cmd_done), 1);
        chk("inv_wr_en", KEY_W'(tcam_wr_en), 0);
        chk("inv_ready", KEY_W'(cmd_ready), 1);
        issue(2'd3, 4'd2, '1, '1, waited);
        @(negedge clk);
        chk("rsv_done", KEY_W'(cmd_done), 1);
        chk("rsv_wr_en", KEY_W'(tcam_wr_en), 0);

        // Back-to-back writes with cmd_valid held.
        issue(2'd0, 4'd3, 128'h1234_5678, 128'hFF00, waited);
        issue(2'd0, 4'd7, 128'hDEAD_BEEF_0000_0001, 128'h3, waited);
        chk("b2b_accept_cycle", KEY_W'(waited), 3);
        repeat (3) @(negedge clk);
        chk("b2b_valid", KEY_W'(entry_valid), 16'h0088);
        chk("b2b_done", KEY_W'(cmd_done), 1);
        @(negedge clk);
        chk("b2b_op_count", KEY_W'(op_count), KEY_W'(exp_cnt()));

        // Fill every entry, then clear all.
        for (int i = 0; i < ENTRIES; i++)
            issue(2'd0, IDX_W'(i), {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, waited);
        repeat (3) @(negedge clk);
        chk("fill_valid", KEY_W'(entry_valid), 16'hFFFF);
        @(negedge clk);
        issue(2'd2, 4'd0, '0, '0, waited);
        @(negedge clk);
        chk("clr_c1_valid", KEY_W'(entry_valid), 0);
        chk("clr_c1_ready", KEY_W'(cmd_ready), 0);
        chk("clr_c1_wr_en", KEY_W'(tcam_wr_en), 1);
        repeat (31) @(negedge clk);
        chk("clr_c32_wr_en", KEY_W'(tcam_wr_en), 1);
        chk("clr_c32_done", KEY_W'(cmd_done), 0);
        @(negedge clk);
        chk("clr_done", KEY_W'(cmd_done), 1);
        chk("clr_ready", KEY_W'(cmd_ready), 1);
        chk("clr_init_done", KEY_W'(init_done), 1);
        @(negedge clk);
        chk("clr_op_count", KEY_W'(op_count), KEY_W'(exp_cnt()));

        // Reset during WR_MASK aborts the write and restarts the scrub at entry 0.
        cmd_op = 2'd0; cmd_addr = 4'd9; cmd_value = 128'h55; cmd_mask = 128'hAA; cmd_valid = 1'b1;
        wq.push_back('{m: 1'b0, a: 4'd9, d: 128'h55});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_c1_wr_en", KEY_W'(tcam_wr_en), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", KEY_W'(tcam_wr_en), 0);
        chk("abort_done", KEY_W'(cmd_done), 0);
        chk("abort_valid", KEY_W'(entry_valid), 0);
        chk("abort_init_done", KEY_W'(init_done), 0);
        chk("abort_op_count", KEY_W'(op_count), 0);
        exp_valid = '0;
        exp_ops = 0;
        push_sweep();
        rst = 1'b0;
        @(negedge clk);
        chk("reinit_wr_en", KEY_W'(tcam_wr_en), 1);
        chk("reinit_addr", KEY_W'(tcam_wr_addr), 0);
        repeat (32) @(negedge clk);
        chk("reinit_done", KEY_W'(init_done), 1);
        chk("reinit_valid", KEY_W'(entry_valid), 0);

        chk("wr_queue_empty", KEY_W'(wq.size()), 0);
        chk("done_queue_empty", KEY_W'(dq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_update_ctrl.md
# tcam_update_ctrl

Control-plane update sequencer for the packet-classification TCAM. It accepts rule commands from the processor over a valid/ready handshake and drives the TCAM write port with one value write then one mask write per rule. It maintains a per-entry valid bitmap that the lookup stage ANDs with the TCAM hit, so a half-written rule is never reported as a hit. After reset it scrubs every entry before accepting commands.

## Interface
- KEY_W, 128, TCAM key/rule width
- ENTRIES, 16, TCAM entries; power of two; IDX_W = $clog2(ENTRIES)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 = write rule, 01 = invalidate entry, 10 = clear all, 11 = reserved (accepted, no-op)
- cmd_addr  in  IDX_W  target entry
- cmd_value  in  KEY_W  rule value
- cmd_mask  in  KEY_W  rule mask (1 = don't care)
- tcam_wr_en  out  1  TCAM write strobe
- tcam_wr_is_mask  out  1  0 = value, 1 = mask
- tcam_wr_addr  out  IDX_W  TCAM write address
- tcam_wr_data  out  KEY_W  TCAM write data
- entry_valid  out  ENTRIES  per-entry valid bitmap
- cmd_done  out  1  one-cycle pulse, command completed
- init_done  out  1  high once the post-reset scrub finishes, stays high
- op_count  out  16  completed-command counter (see Configuration)

## Operation
- States: INIT, IDLE, WR_VAL, WR_MASK, SCRUB.
- INIT: sweeps idx 0..ENTRIES-1. Each entry writes value = 0, then mask = 0, taking 2*ENTRIES cycles. Then init_done = 1 and the FSM goes to IDLE.
- IDLE: cmd_ready = 1 only here. On accept, the command fields are latched.
  - Write: clears entry_valid[cmd_addr] at the accept edge, then goes to WR_VAL.
  - Invalidate: clears entry_valid[cmd_addr] at the accept edge and stays IDLE. cmd_done pulses the next cycle.
  - Clear all: clears the whole entry_valid at the accept edge, then goes to SCRUB.
  - Reserved: stays IDLE. cmd_done pulses the next cycle.
- WR_VAL: tcam_wr_en = 1, is_mask = 0, addr/data = latched addr/value. Goes to WR_MASK.
- WR_MASK: tcam_wr_en = 1, is_mask = 1, data = latched mask. At the exit edge it sets entry_valid[addr], raises cmd_done for the next cycle, and goes to IDLE.
- SCRUB: same sweep as INIT (init_done stays 1). Exits to IDLE with a cmd_done pulse.
- tcam_wr_* are registered outputs, high only in the WR_VAL, WR_MASK, INIT and SCRUB cycles. Outside those cycles, wr_en = 0 and addr/data/is_mask hold 0.
- Sweep index is an IDX_W+1-bit counter, so the terminal count is ENTRIES with no wrap ambiguity.
- Lookups are never stalled. An entry under update reads invalid, so the qualified lookup sees a miss for that entry. Lower-index priority is unchanged.

## Timing
- Reset values:
  - FSM = INIT; cmd_ready = 0, init_done = 0, cmd_done = 0.
  - entry_valid = 0, op_count = 0.
  - tcam_wr_en = 0, is_mask = 0, addr = 0, data = 0.
- First TCAM write occurs in the first cycle after rst deasserts. init_done rises 2*ENTRIES cycles later, together with cmd_ready.
- Write rule: accept at edge T0. WR_VAL in cycle 1, WR_MASK in cycle 2. entry_valid set and cmd_done = 1 in cycle 3, with cmd_ready = 1 again that cycle. Throughput is one write per 3 cycles.
- Invalidate: entry_valid bit is low from cycle 1. cmd_done and cmd_ready are high in cycle 1.
- Clear all: entry_valid = 0 from cycle 1. The sweep runs in cycles 1..2*ENTRIES. cmd_done is high in cycle 2*ENTRIES+1.
- The new rule is fully in the TCAM at the same edge that sets its valid bit.
- cmd_valid while cmd_ready = 0 is held by the requester. Inputs are sampled only at the accept edge.
- Reset mid-operation aborts the command with no cmd_done, clears entry_valid, and restarts INIT.

## Configuration
- TCAM_UPD_CNT_EN defined: op_count increments by 1 in each cmd_done cycle and saturates at 16'hFFFF. It is not cleared by clear-all, only by rst.
- TCAM_UPD_CNT_EN undefined: op_count is tied to 0 and no counter is synthesized.

## Test plan
- Reset release -> tcam_wr_en high for 32 cycles (ENTRIES = 16), alternating is_mask 0/1, addr 0..15, data 0. Then init_done = 1, cmd_ready = 1, entry_valid = 0.
- Write addr 5, value 0xAB, mask 0x0F -> cycle 1 writes value 0xAB to addr 5. Cycle 2 writes mask 0x0F to addr 5. In cycle 3, entry_valid = 16'h0020 and cmd_done = 1.
- Back-to-back writes to addr 3 and addr 7 with cmd_valid held -> second accept lands in cycle 3, and entry_valid = 16'h0088 after cycle 6.
- Invalidate addr 5 after a write -> entry_valid[5] = 0 next cycle, cmd_done = 1, no TCAM write.
- Clear all with entry_valid = 16'hFFFF -> entry_valid = 0 next cycle, then a 32-cycle scrub, then cmd_done. With TCAM_UPD_CNT_EN, op_count has advanced by 1.
- Assert rst during WR_MASK -> no cmd_done, entry_valid = 0, and INIT restarts at addr 0.
